// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the oversampling UART receiver
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic RX_IDLE_LEVEL = 1'b1;
  localparam int   MAX_DATA_BITS = 9;

  // Returns the parity bit a correct transmitter would send for this data word.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx double-flop synchroniser and sample_clk edge-to-tick converter
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sample_clk,
  input  logic rx,
  output logic rx_s,
  output logic tick
);

  logic rx_meta_q;
  logic rx_s_q;
  logic sample_clk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= RX_IDLE_LEVEL;
      rx_s_q       <= RX_IDLE_LEVEL;
      sample_clk_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      sample_clk_q <= sample_clk;
    end
  end

  assign rx_s = rx_s_q;
  // Both edges of sample_clk count as one oversample each.
  assign tick = sample_clk ^ sample_clk_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 16x oversampling UART receiver with valid/ready output and error flags
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLE     = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(SAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID = TW'(SAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_s;
  logic tick;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .sample_clk (sample_clk),
    .rx         (rx),
    .rx_s       (rx_s),
    .tick       (tick)
  );

  rx_state_e            state_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, frame_err_q, parity_err_q, overrun_q;
  logic                 at_mid, at_end, line_low;

  always_comb begin
    at_mid     = (tick_cnt_q == TICK_MID);
    at_end     = (tick_cnt_q == TICK_END);
    line_low   = (rx_s != RX_IDLE_LEVEL);
    tick_cnt_d = tick_cnt_q + TW'(1);
    shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
    par_err_d  = (PARITY_EN != 0) &&
                 (rx_s != parity_calc(MAX_DATA_BITS'(shift_q), PARITY_ODD != 0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (line_low) begin
            state_q    <= START;
            tick_cnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (at_mid) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              par_err_q  <= 1'b0;
              state_q    <= line_low ? DATA : IDLE;
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (at_end) begin
              tick_cnt_q <= '0;
              shift_q    <= shift_d;
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (at_end) begin
              tick_cnt_q <= '0;
              par_err_q  <= par_err_d;
              state_q    <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (at_end) begin
              tick_cnt_q <= '0;
              state_q    <= IDLE;
              // A pending word not taken this cycle wins; the new one is dropped.
              if (!rx_valid_q || rx_ready) begin
                rx_valid_q   <= 1'b1;
                rx_data_q    <= shift_q;
                frame_err_q  <= line_low;
                parity_err_q <= par_err_q;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample (8N1 and 8E1 instances)
module tb_uart_rx_oversample;

  localparam int BIT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_clk = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1;

  logic [7:0] d_a, d_b;
  logic v_a, fe_a, pe_a, ov_a, busy_a;
  logic v_b, fe_b, pe_b, ov_b, busy_b;

  uart_rx_oversample #(.DATA_BITS(8), .SAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .rx(rx_a),
    .rx_data(d_a), .rx_valid(v_a), .rx_ready(rdy_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a)
  );

  uart_rx_oversample #(.DATA_BITS(8), .SAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .sample_clk(sample_clk), .rx(rx_b),
    .rx_data(d_b), .rx_valid(v_b), .rx_ready(rdy_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int unsigned sc_div = 0;
  always @(posedge clk) begin
    if (sc_div == 3) begin
      sc_div     <= 0;
      sample_clk <= ~sample_clk;
    end else begin
      sc_div <= sc_div + 1;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int checks = 0;
  int errors = 0;
  int ovr_a = 0;
  int ovr_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ov_a) ovr_a++;
      if (ov_b) ovr_b++;
      if (v_a && rdy_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: got word %0h expected none", d_a);
        end else begin
          e_a = q_a.pop_front();
          chk("a_data", {24'd0, d_a}, {24'd0, e_a.d});
          chk("a_frame_err", {31'd0, fe_a}, {31'd0, e_a.fe});
          chk("a_parity_err", {31'd0, pe_a}, {31'd0, e_a.pe});
        end
      end
      if (v_b && rdy_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got word %0h expected none", d_b);
        end else begin
          e_b = q_b.pop_front();
          chk("b_data", {24'd0, d_b}, {24'd0, e_b.d});
          chk("b_frame_err", {31'd0, fe_b}, {31'd0, e_b.fe});
          chk("b_parity_err", {31'd0, pe_b}, {31'd0, e_b.pe});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input bit par, input bit stop);
    drive(sel, 1'b0);
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_clk(BIT);
    end
    if (par_en) begin
      drive(sel, par);
      wait_clk(BIT);
    end
    drive(sel, stop);
    // A low stop bit is cut short so the restart it causes fails its mid-bit check.
    if (stop) wait_clk(BIT);
    else      wait_clk(44);
    drive(sel, 1'b1);
    wait_clk(2 * BIT);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v55;
    int n;
    v55 = 8'h55;

    wait_clk(5);
    chk("rst_valid_a", {31'd0, v_a}, 0);
    chk("rst_data_a", {24'd0, d_a}, 0);
    chk("rst_flags_a", {29'd0, fe_a, pe_a, ov_a}, 0);
    chk("rst_busy_a", {31'd0, busy_a}, 0);
    chk("rst_valid_busy_b", {30'd0, v_b, busy_b}, 0);
    reset = 1'b0;
    wait_clk(10);

    q_a.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);

    drive(1'b0, 1'b0);
    wait_clk(12);
    chk("glitch_busy_set", {31'd0, busy_a}, 1);
    drive(1'b0, 1'b1);
    n = 0;
    while (busy_a && n < 200) begin
      wait_clk(1);
      n++;
    end
    chk("glitch_busy_clear", {31'd0, busy_a}, 0);
    wait_clk(BIT);

    q_a.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    q_b.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    q_b.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);

    rdy_a = 1'b0;
    q_a.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("overrun_pulses", ovr_a, 1);
    chk("held_valid", {31'd0, v_a}, 1);
    chk("held_data", {24'd0, d_a}, 32'h11);
    rdy_a = 1'b1;
    wait_clk(3);
    chk("valid_drop", {31'd0, v_a}, 0);

    drive(1'b0, 1'b0);
    wait_clk(BIT);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, v55[i]);
      wait_clk(BIT);
    end
    drive(1'b0, v55[4]);
    wait_clk(BIT / 2);
    chk("pre_reset_busy", {31'd0, busy_a}, 1);
    reset = 1'b1;
    wait_clk(1);
    chk("midrst_outputs", {22'd0, d_a, v_a, fe_a, pe_a, ov_a}, 0);
    chk("midrst_busy", {31'd0, busy_a}, 0);
    reset = 1'b0;
    drive(1'b0, 1'b1);
    wait_clk(BIT);

    q_a.push_back('{8'h66, 1'b0, 1'b0});
    send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 2000) begin
      wait_clk(1);
      n++;
    end
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    chk("overrun_total_a", ovr_a, 1);
    chk("overrun_total_b", ovr_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
